// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage with a skid buffer. in_ready depends only on
// registered state, so the stage breaks the out_ready -> in_ready timing path
// while still sustaining one transfer per cycle.
module pipe_stage_skid #(
  parameter int unsigned      WIDTH   = 64,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic push;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Registered occupancy count, decoded straight from state.
  always_comb begin
    count = 2'd0;
    case (state_q)
      ONE:     count = 2'd1;
      FULL:    count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  // Next-state and entry-load decode.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_main_in = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register; flush overrides any simultaneous push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers; main keeps its value whenever it is not reloaded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else if (flush) begin
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus randomized
// traffic, compared against a queue-based model of the stage.
module tb_pipe_stage_skid;

  localparam int unsigned      W    = 16;
  localparam logic [W-1:0]     RVAL = 16'h4000;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         flush;
  logic [1:0]   count;

  int unsigned chk_cnt;
  int unsigned pass_cnt;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_out;

  pipe_stage_skid #(
    .WIDTH   (W),
    .RST_VAL (RVAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    n = mq.size();
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, n > 0});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, n < 2});
    chk({tag, ".count"},     {30'd0, count},     n);
    chk({tag, ".out_data"},  {16'd0, out_data},  {16'd0, m_out});
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = RVAL;
  endtask

  // Drive one cycle of inputs, advance the model by the same rules, and compare.
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                       input logic r, input logic f);
    logic do_push;
    logic do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    do_push = v && (mq.size() < 2);
    do_pop  = r && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (f) begin
      mq.delete();
      m_out = RVAL;
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(d);
      if (mq.size() > 0) m_out = mq[0];
    end
    check_all(tag);
  endtask

  initial begin
    chk_cnt   = 0;
    pass_cnt  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    model_reset();

    // Asynchronous reset, asserted between edges and checked before any edge.
    #3 rst = 1'b0;
    #1;
    check_all("reset_async");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset_release");

    // Streaming: one transfer per cycle, count stays 1.
    for (int i = 1; i <= 8; i++) begin
      cycle("stream", 1'b1, W'(i), 1'b1, 1'b0);
      chk("stream.data_seq", {16'd0, out_data}, i);
    end
    cycle("stream_drain", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Backpressure: fill to FULL, then drain in order.
    cycle("bp_a", 1'b1, 16'hAAAA, 1'b0, 1'b0);
    cycle("bp_b", 1'b1, 16'hBBBB, 1'b0, 1'b0);
    chk("bp.full_count", {30'd0, count}, 32'd2);
    chk("bp.head", {16'd0, out_data}, 32'h0000AAAA);
    cycle("bp_blocked", 1'b1, 16'hDEAD, 1'b0, 1'b0);
    cycle("bp_pop1", 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("bp.second", {16'd0, out_data}, 32'h0000BBBB);
    cycle("bp_pop2", 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("bp.empty_count", {30'd0, count}, 32'd0);
    chk("bp.hold_data", {16'd0, out_data}, 32'h0000BBBB);

    // Flush priority over simultaneous push and pop.
    cycle("fl_a", 1'b1, 16'hAAAA, 1'b0, 1'b0);
    cycle("fl_b", 1'b1, 16'hBBBB, 1'b0, 1'b0);
    cycle("flush", 1'b1, 16'hCCCC, 1'b1, 1'b1);
    chk("flush.data", {16'd0, out_data}, 32'h00004000);
    chk("flush.valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle("flush_after", 1'b0, 16'hCCCC, 1'b1, 1'b0);
      chk("flush.no_cccc", {31'd0, out_valid}, 32'd0);
    end

    // Simultaneous push and pop in ONE.
    cycle("pp_head", 1'b1, 16'h1111, 1'b0, 1'b0);
    cycle("pp_both", 1'b1, 16'h2222, 1'b1, 1'b0);
    chk("pp.data", {16'd0, out_data}, 32'h00002222);
    chk("pp.count", {30'd0, count}, 32'd1);
    cycle("pp_drain", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Reset mid-operation while FULL.
    cycle("rm_a", 1'b1, 16'h5555, 1'b0, 1'b0);
    cycle("rm_b", 1'b1, 16'h6666, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all("rm_async");
    @(posedge clk);
    #1;
    check_all("rm_held");
    #2 rst = 1'b1;
    cycle("rm_push", 1'b1, 16'h3333, 1'b0, 1'b0);
    chk("rm.data", {16'd0, out_data}, 32'h00003333);
    cycle("rm_drain", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      cycle("rand", ($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0,
            ($urandom % 40) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL provide parameter WIDTH, default 64, payload width in bits (WIDTH >= 1).
REQ-002 SHALL provide parameter RST_VAL, default {WIDTH{1'b0}}, payload value loaded on reset and flush.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 SHALL provide port in_valid  input  1  upstream stage presents a payload.
REQ-006 SHALL provide port in_ready  output  1  stage can accept a payload this cycle.
REQ-007 SHALL provide port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL provide port out_valid  output  1  out_data holds a valid payload.
REQ-009 SHALL provide port out_ready  input  1  downstream stage consumes the payload this cycle.
REQ-010 SHALL provide port out_data  output  WIDTH  head payload.
REQ-011 SHALL provide port flush  input  1  synchronous kill of all held payloads.
REQ-012 SHALL provide port count  output  2  number of held payloads (0..2).

Function
REQ-013 SHALL hold two entries, main (head, drives out_data) and skid, giving three states: EMPTY (count 0), ONE (main valid), FULL (main and skid valid).
REQ-014 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready, both sampled at the rising edge.
REQ-015 SHALL drive in_ready = (state != FULL), derived from registered state only; no combinational path from out_ready to in_ready.
REQ-016 SHALL drive out_valid = (state != EMPTY) and count from registered state.
REQ-017 SHALL, in EMPTY: on push, load main <= in_data and go to ONE; else stay EMPTY.
REQ-018 SHALL, in ONE: on push and pop, load main <= in_data and stay ONE; on push only, load skid <= in_data and go to FULL; on pop only, go to EMPTY; else hold.
REQ-019 SHALL, in FULL: on pop, move main <= skid and go to ONE; else hold (push impossible since in_ready = 0).
REQ-020 SHALL preserve strict FIFO order; no payload dropped or duplicated except on flush.
REQ-021 SHALL give 1-cycle latency from push to out_valid and sustain one transfer per cycle when out_ready is held 1.
REQ-022 SHALL leave out_data unchanged whenever main is not reloaded, including while out_valid = 0.
REQ-023 SHALL ignore in_data when push = 0 and ignore out_ready when out_valid = 0.
REQ-024 SHALL, when flush = 1 at an edge, go to EMPTY and load main and skid with RST_VAL, overriding any simultaneous push or pop; the payload offered in that cycle is discarded.
REQ-025 SHALL report count = 2 only in FULL; count never exceeds 2.

Reset
REQ-026 SHALL, while rst = 0, immediately and independently of clk force state EMPTY, main = skid = RST_VAL, giving out_valid = 0, in_ready = 1, count = 0, out_data = RST_VAL.
REQ-027 SHALL discard all held payloads when rst asserts mid-operation, and resume normal operation on the first rising edge after rst returns to 1.

Verification
REQ-028 SHALL verify reset: WIDTH=16, RST_VAL=16'h4000, rst=0 asserted between clock edges -> out_data=16'h4000, out_valid=0, in_ready=1, count=0 without waiting for a clock edge.
REQ-029 SHALL verify streaming: out_ready=1, push 16'h0001..16'h0008 on consecutive cycles -> out_data 0001..0008 one cycle later each, in_ready stays 1, count stays 1.
REQ-030 SHALL verify backpressure: out_ready=0, push A=16'hAAAA then B=16'hBBBB -> count=2, in_ready=0, out_data=AAAA; raise out_ready -> pops AAAA then BBBB, count 2->1->0.
REQ-031 SHALL verify flush priority: FULL with AAAA/BBBB, flush=1 with in_valid=1, in_data=16'hCCCC and out_ready=1 -> next cycle count=0, out_valid=0, out_data=16'h4000; CCCC never emerges.
REQ-032 SHALL verify simultaneous push/pop in ONE: head 16'h1111, push 16'h2222 with out_ready=1 -> next cycle out_data=2222, count=1.
REQ-033 SHALL verify reset mid-operation: FULL, assert rst for 1 cycle -> state EMPTY; after release, push 16'h3333 -> out_data=3333 one cycle later.
